// File: rtl/cpu8_core.sv
// cpu8_core: 8-bit register-machine CPU with an 8x8 LED-matrix register display.
//
// The core fetches 16-bit instruction words from a registered-read program
// memory and executes one instruction every two clocks (FETCH then EXEC).
// Registers r0..r7 are scanned onto the matrix one row per counter[12:10] value.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active high
//   counter  in   free-running counter; bits [12:10] select the display row
//   dout     in   instruction word from program memory (valid during EXEC)
//   pc_out   out  byte program counter (word address = pc_out/2)
//   led      out  r0[3:0]
//   row      out  one-hot row select, active high
//   col      out  column data, active low (~r[sel])
module cpu8_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] counter,
  input  logic [15:0] dout,
  output logic [10:0] pc_out,
  output logic [3:0]  led,
  output logic [7:0]  row,
  output logic [7:0]  col
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic        exec_en;

  logic [10:0] pc_reg, pc_next;
  logic [7:0]  r_reg [8];

  logic [7:0]  instr;
  logic [2:0]  rs_idx;
  logic [3:0]  imm;
  logic [10:0] jump_tgt;
  logic [7:0]  r0_val, rr_val;

  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  wr_sel;

  logic [2:0]  sel;

  // Upper instruction byte and unused counter bits are intentionally ignored.
  logic        unused_bits;
  assign unused_bits = ^{counter[23:13], counter[9:0], dout[15:8]};

  // ---------------- phase FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = EXEC;
      EXEC:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    exec_en = 1'b0;
    case (state_reg)
      EXEC:    exec_en = 1'b1;
      default: exec_en = 1'b0;
    endcase
  end

  // ---------------- decode / execute ----------------
  assign instr    = dout[7:0];
  assign rs_idx   = instr[2:0];
  assign imm      = instr[3:0];
  assign jump_tgt = {6'b0, imm, 1'b0};
  assign r0_val   = r_reg[0];
  assign rr_val   = r_reg[rs_idx];

  // At most one register write per instruction; ALU operands are the
  // pre-instruction register values, so "add r0" doubles r0.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'd0;
    pc_next = pc_reg + 11'd2;
    case (instr[7:6])
      2'b00: begin
        wr_en   = 1'b1;
        wr_addr = instr[5:3];
        wr_data = rr_val;
      end
      2'b01: begin
        wr_en = 1'b1;
        case (instr[5:3])
          3'b000: begin wr_addr = 3'd0;   wr_data = r0_val + rr_val;         end
          3'b001: begin wr_addr = 3'd0;   wr_data = r0_val - rr_val;         end
          3'b010: begin wr_addr = 3'd0;   wr_data = r0_val & rr_val;         end
          3'b011: begin wr_addr = 3'd0;   wr_data = r0_val | rr_val;         end
          3'b100: begin wr_addr = rs_idx; wr_data = rr_val + 8'd1;           end
          3'b101: begin wr_addr = rs_idx; wr_data = rr_val - 8'd1;           end
          3'b110: begin wr_addr = rs_idx; wr_data = {rr_val[0], rr_val[7:1]}; end
          default: begin wr_addr = rs_idx; wr_data = {rr_val[6:0], rr_val[7]}; end
        endcase
      end
      2'b10: begin
        case (instr[5:4])
          2'b00: if (r0_val == 8'd0) pc_next = jump_tgt;
          2'b01: pc_next = jump_tgt;
          2'b10: begin
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = {4'b0, imm};
          end
          default: begin
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = {imm, r0_val[3:0]};
          end
        endcase
      end
      default: ;  // reserved opcodes behave as nop
    endcase
  end

  // Per-register write strobes, qualified by the EXEC phase.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wr_sel
      assign wr_sel[gi] = exec_en & wr_en & (wr_addr == 3'(gi));
    end
  endgenerate

  // Reset has priority, so a reset landing on EXEC discards the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= 11'd0;
      for (int k = 0; k < 8; k++) r_reg[k] <= 8'd0;
    end else begin
      if (exec_en) pc_reg <= pc_next;
      for (int k = 0; k < 8; k++) begin
        if (wr_sel[k]) r_reg[k] <= wr_data;
      end
    end
  end

  // ---------------- outputs ----------------
  assign sel    = counter[12:10];
  assign row    = 8'b1 << sel;
  assign col    = ~r_reg[sel];
  assign led    = r_reg[0][3:0];
  assign pc_out = pc_reg;

endmodule

// File: tb/tb_cpu8_core.sv
// Testbench for cpu8_core: instruction-level reference model compared every
// cycle, plus directed programs with hand-computed literal expectations.
module tb_cpu8_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] counter = 24'd0;
  logic [15:0] dout = 16'd0;
  logic [10:0] pc_out;
  logic [3:0]  led;
  logic [7:0]  row;
  logic [7:0]  col;

  cpu8_core dut (
    .clk     (clk),
    .rst     (rst),
    .counter (counter),
    .dout    (dout),
    .pc_out  (pc_out),
    .led     (led),
    .row     (row),
    .col     (col)
  );

  always #5 clk = ~clk;

  // Program memory with registered read.
  logic [15:0] mem [1024];
  always @(posedge clk) dout <= mem[pc_out[10:1]];

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (one instruction per two clocks) -------
  int         m_r [8];
  int         m_pc;
  bit         m_exec  = 1'b0;
  bit         m_valid = 1'b0;
  logic [15:0] m_word;
  int         m_i;

  task automatic model_step();
    int op, rr, imm;
    op  = (m_i >> 3) & 7;
    rr  = m_i & 7;
    imm = m_i & 15;
    m_pc = (m_pc + 2) % 2048;
    case (m_i >> 6)
      0: m_r[(m_i >> 3) & 7] = m_r[rr];
      1: begin
        case (op)
          0: m_r[0]  = (m_r[0] + m_r[rr]) % 256;
          1: m_r[0]  = (m_r[0] - m_r[rr] + 256) % 256;
          2: m_r[0]  = m_r[0] & m_r[rr];
          3: m_r[0]  = m_r[0] | m_r[rr];
          4: m_r[rr] = (m_r[rr] + 1) % 256;
          5: m_r[rr] = (m_r[rr] + 255) % 256;
          6: m_r[rr] = (m_r[rr] / 2) + (m_r[rr] % 2) * 128;
          default: m_r[rr] = (m_r[rr] * 2) % 256 + (m_r[rr] / 128);
        endcase
      end
      2: begin
        case ((m_i >> 4) & 3)
          0: if (m_r[0] == 0) m_pc = imm * 2;
          1: m_pc = imm * 2;
          2: m_r[0] = imm;
          default: m_r[0] = imm * 16 + (m_r[0] % 16);
        endcase
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_exec  = 1'b0;
      m_pc    = 0;
      for (int k = 0; k < 8; k++) m_r[k] = 0;
    end else if (m_valid) begin
      if (!m_exec) begin
        m_word = mem[m_pc / 2];
        m_i    = int'(m_word[7:0]);
        m_exec = 1'b1;
      end else begin
        model_step();
        m_exec = 1'b0;
      end
    end
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int s;
    logic [7:0] exp_col;
    logic [7:0] exp_row;
    if (m_valid) begin
      s       = int'(counter[12:10]);
      exp_col = 8'(~m_r[s]);
      exp_row = 8'(1 << s);
      cmp("model pc_out", 16'(pc_out), 16'(m_pc));
      cmp("model led",    16'(led),    16'(m_r[0] % 16));
      cmp("model row",    16'(row),    16'(exp_row));
      cmp("model col",    16'(col),    16'(exp_col));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    cmp(name, act, exp);
    $display("check %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    logic [7:0] inv;
    inv     = ~exp;
    counter = 24'(idx) << 10;
    #1;
    lit($sformatf("r%0d", idx), 16'(col), 16'(inv));
    counter = 24'd0;
  endtask

  task automatic restart(input logic [15:0] prog[$]);
    rst = 1'b1;
    counter = 24'd0;
    run(2);
    for (int k = 0; k < 1024; k++) mem[k] = 16'h0000;
    foreach (prog[k]) mem[k] = prog[k];
    rst = 1'b0;
  endtask

  logic [15:0] prog [$];

  initial begin
    // Reset with memory returning mvi 5 everywhere.
    for (int k = 0; k < 1024; k++) mem[k] = 16'h00A5;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      lit("rst pc_out", 16'(pc_out), 16'd0);
      lit("rst led",    16'(led),    16'd0);
      lit("rst col",    16'(col),    16'h00FF);
    end
    rst = 1'b0;
    run(2);
    lit("first exec led", 16'(led), 16'd5);
    lit("first exec pc",  16'(pc_out), 16'd2);

    // Boot program: r0=2, chain builds r1..r7 = 3..9, then jmp 2.
    prog = '{16'h00A1, 16'h0078, 16'h0000,
             16'h0008, 16'h0061, 16'h0011, 16'h0062, 16'h001A, 16'h0063,
             16'h0023, 16'h0064, 16'h002C, 16'h0065, 16'h0035, 16'h0066,
             16'h003E, 16'h0067, 16'h0092};
    restart(prog);
    run(36);
    lit("boot jmp pc", 16'(pc_out), 16'd4);
    for (int k = 0; k < 8; k++) check_reg(k, 8'(k + 2));

    // Rotate wrap: r0 = 80 -> lrot -> 01 -> rrot -> 80.
    prog = '{16'h00B8, 16'h0078, 16'h0070, 16'h0093};
    restart(prog);
    run(2);
    check_reg(0, 8'h80);
    run(2);
    check_reg(0, 8'h01);
    run(2);
    check_reg(0, 8'h80);

    // Arithmetic wrap and ALU group.
    prog = '{16'h00AF, 16'h00BF, 16'h0010, 16'h0062, 16'h006A, 16'h00A5,
             16'h0008, 16'h00A3, 16'h0049, 16'h0041, 16'h0052, 16'h0059,
             16'h009C};
    restart(prog);
    run(8);
    check_reg(2, 8'h00);
    run(2);
    check_reg(2, 8'hFF);
    run(8);
    check_reg(0, 8'hFE);
    run(6);
    check_reg(0, 8'h07);
    check_reg(1, 8'h05);

    // jz taken (r0=0) then not taken (r0=1).
    prog = '{16'h00A0, 16'h0087, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h00A1, 16'h0087, 16'h0099};
    restart(prog);
    run(4);
    lit("jz taken pc", 16'(pc_out), 16'd14);
    run(4);
    lit("jz not taken pc", 16'(pc_out), 16'd18);

    // Display: r3 = A5, r0 = 06, select row 3 with other counter bits set.
    prog = '{16'h00A5, 16'h00BA, 16'h0018, 16'h00A6, 16'h0094};
    restart(prog);
    run(10);
    counter = 24'hABCC00;
    #1;
    lit("disp row", 16'(row), 16'h0008);
    lit("disp col", 16'(col), 16'h005A);
    lit("disp led", 16'(led), 16'h0006);
    counter = 24'd0;

    // Reset landing on EXEC of mvi 9 discards it.
    prog = '{16'h00A9, 16'h0090};
    restart(prog);
    tick();
    rst = 1'b1;
    tick();
    lit("abort led", 16'(led), 16'd0);
    lit("abort pc",  16'(pc_out), 16'd0);
    lit("abort col", 16'(col), 16'h00FF);
    rst = 1'b0;
    run(2);
    lit("after abort led", 16'(led), 16'd9);
    lit("after abort pc",  16'(pc_out), 16'd2);

    run(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
